dmem_ctrl: RTL and testbench



---
 rtl/dmem_if.sv | 19 +
 rtl/dmem_ctrl.sv | 73 +++++++
 tb/tb_dmem_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage request/response channel to the data-memory controller
// Ports: req_valid/req_ready handshake, req_we/req_size/req_unsigned/req_addr/req_wdata
// request fields, rsp_valid/rsp_rdata/rsp_err one-cycle response; master = MEM stage, slave = dmem_ctrl
interface dmem_if #(parameter int ADDR_W = 32);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-strobed data memory with sized/extended loads and range/size error reporting
// Ports: clk, rst (sync, active-high), bus (dmem_if.slave: valid/ready request, one-cycle response pulse)
// Option: define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of masking the low bits
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic clk,
  input logic rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_n;
  logic [3:0][7:0] mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] off;
  logic [AW-1:0] idx;
  logic [1:0] lane, lane_q, size_q;
  logic [3:0] strb;
  logic [31:0] wd, rd_q, hold_q, sh, ext;
  logic mis, err, acc, uns_q, ld_q, err_q;
  always_comb begin
    off = bus.req_addr - BASE_ADDR;
    idx = off[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (bus.req_size == 2'd1 && off[0]) || (bus.req_size == 2'd2 && off[1:0] != 2'd0);
`else
    mis = 1'b0;
`endif
    // bits above the array span being nonzero means out of range, including wrap below BASE
    err = (&bus.req_size) || (|(off >> (AW + 2))) || mis;
    lane = bus.req_size == 2'd0 ? off[1:0] : bus.req_size == 2'd1 ? {off[1], 1'b0} : 2'd0;
    strb = bus.req_size == 2'd0 ? 4'b0001 << lane : bus.req_size == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} : bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    acc = bus.req_valid && bus.req_ready;
  end
  always_ff @(posedge clk) begin
    if (acc && bus.req_we && !err)
      for (int i = 0; i < 4; i++)
        if (strb[i]) mem[idx][i] <= wd[8*i +: 8];
    if (acc) begin
      rd_q <= mem[idx];
      lane_q <= lane;
      size_q <= bus.req_size;
      uns_q <= bus.req_unsigned;
      ld_q <= !bus.req_we && !err;
      err_q <= err;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (bus.req_valid ? RESP : IDLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else if (state == RESP) hold_q <= ext;
  end
  always_comb begin
    sh = rd_q >> {lane_q, 3'b000};
    ext = !ld_q ? 32'd0 :
          size_q == 2'd0 ? {{24{!uns_q && sh[7]}}, sh[7:0]} :
          size_q == 2'd1 ? {{16{!uns_q && sh[15]}}, sh[15:0]} : sh;
    bus.req_ready = state == IDLE;
    // reset in the response cycle suppresses the pulse
    bus.rsp_valid = state == RESP && !rst;
    bus.rsp_err = bus.rsp_valid && err_q;
    bus.rsp_rdata = state == RESP ? ext : hold_q;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  dmem_if #(.ADDR_W(32)) bus();
  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  logic [7:0] mmem [0:4*DEPTH-1];
  bit m_busy = 0;
  bit m_err = 0;
  logic [31:0] m_rdata = 0;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_accept();
    logic [31:0] off, ea, v;
    int n;
    bit e;
    off = bus.req_addr - BASE;
    n = bus.req_size == 0 ? 1 : bus.req_size == 1 ? 2 : 4;
    e = bus.req_size == 3 || off >= 32'(4 * DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    e = e || (off % n != 0);
`endif
    ea = off - off % n;
    v = 0;
    if (!e)
      for (int i = 0; i < n; i++)
        if (bus.req_we) mmem[ea + i] = bus.req_wdata[8*i +: 8];
        else v[8*i +: 8] = mmem[ea + i];
    if (n < 4 && !bus.req_unsigned && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
    m_busy = 1;
    m_err = e;
    m_rdata = (e || bus.req_we) ? 32'd0 : v;
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_err = 0;
      m_rdata = 0;
    end else if (m_busy) m_busy = 0;
    else if (bus.req_valid) model_accept();
  end
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      chk("ready", bus.req_ready, !m_busy);
      chk("valid", bus.rsp_valid, m_busy && !rst);
      chk("rdata", bus.rsp_rdata, m_rdata);
      chk("err", bus.rsp_err, m_busy && !rst && m_err);
    end
  end
  task automatic xact(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
    int w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", bus.req_ready, 1);
    bus.req_valid = 1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    int r;
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_size = 0;
    bus.req_unsigned = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    xact(1, 2, 0, 32'h10, 32'hDEADBEEF);
    #1 chk("sw_valid", bus.rsp_valid, 1);
    xact(0, 2, 0, 32'h10, 0);
    #1 chk("lw_10", bus.rsp_rdata, 32'hDEADBEEF);
    chk("lw_valid", bus.rsp_valid, 1);
    chk("lw_err", bus.rsp_err, 0);
    xact(1, 0, 0, 32'h12, 32'h0000005A);
    xact(0, 2, 0, 32'h10, 0);
    #1 chk("lw_after_sb", bus.rsp_rdata, 32'hDE5ABEEF);
    xact(0, 0, 0, 32'h13, 0);
    #1 chk("lb_13", bus.rsp_rdata, 32'hFFFFFFDE);
    xact(0, 0, 1, 32'h13, 0);
    #1 chk("lbu_13", bus.rsp_rdata, 32'h000000DE);
    xact(0, 1, 0, 32'h12, 0);
    #1 chk("lh_12", bus.rsp_rdata, 32'hFFFFDE5A);
    xact(0, 1, 0, 32'h11, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    #1 chk("lh_11_err", bus.rsp_err, 1);
    chk("lh_11_rdata", bus.rsp_rdata, 0);
`else
    #1 chk("lh_11_err", bus.rsp_err, 0);
    chk("lh_11_rdata", bus.rsp_rdata, 32'hFFFFBEEF);
`endif
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_we = 0;
    bus.req_size = 2;
    bus.req_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("b2b_ready", bus.req_ready, i % 2);
      chk("b2b_valid", bus.rsp_valid, (i % 2) == 0);
      chk("b2b_rdata", bus.rsp_rdata, 32'hDE5ABEEF);
    end
    bus.req_valid = 0;
    xact(1, 2, 0, 32'h1000, 32'hFFFFFFFF);
    #1 chk("oor_hi_err", bus.rsp_err, 1);
    chk("oor_hi_rdata", bus.rsp_rdata, 0);
    xact(1, 2, 0, 32'hFFFFFFFC, 32'hFFFFFFFF);
    #1 chk("oor_lo_err", bus.rsp_err, 1);
    xact(1, 3, 0, 32'h10, 32'hFFFFFFFF);
    #1 chk("size3_err", bus.rsp_err, 1);
    xact(0, 2, 0, 32'h1000, 0);
    #1 chk("oor_ld_rdata", bus.rsp_rdata, 0);
    xact(0, 2, 0, 32'h10, 0);
    #1 chk("unchanged_10", bus.rsp_rdata, 32'hDE5ABEEF);
    chk("unchanged_err", bus.rsp_err, 0);
    xact(1, 2, 0, 32'h20, 32'h12345678);
    rst = 1;
    #1 chk("rst_drop_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("rst_ready_after", bus.req_ready, 1);
    xact(0, 2, 0, 32'h20, 0);
    #1 chk("committed_20", bus.rsp_rdata, 32'h12345678);
    for (int i = 0; i < 16; i++) xact(1, 2, 0, 32'(4 * i), $urandom);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      a = r == 0 ? 32'h1000 + $urandom_range(0, 15) : r == 1 ? 32'hFFFFFFF0 + $urandom_range(0, 15) : 32'($urandom_range(0, 63));
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
